// File: rtl/bcd_digit_scanner.sv
// Binary-to-BCD converter with a multiplexed digit scanner.
// A loaded value is converted serially by double dabble. The result is written
// to the display registers in one cycle, with leading blanking, a minus sign
// and overflow handling. The scanner walks the display registers independently.
module bcd_digit_scanner #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned IN_W     = 8
) (
  input  logic                clk2,
  input  logic                rst,
  input  logic [IN_W-1:0]     value,
  input  logic                signed_mode,
  input  logic                load,
  input  logic                scan_tick,
  output logic [3:0]          BCD,
  output logic [N_DIGITS-1:0] sel_an,
  output logic                busy,
  output logic                overflow
);

  // Decimal digits needed for an IN_W-bit magnitude (log10(2) ~= 0.30103).
  localparam int unsigned NBcd = (IN_W * 30103) / 100000 + 1;
  localparam int unsigned AccW = 4 * NBcd;
  localparam int unsigned PadW = 4 * ((N_DIGITS > NBcd) ? N_DIGITS : NBcd);
  localparam int unsigned CntW = $clog2(IN_W);
  localparam int unsigned IdxW = $clog2(N_DIGITS);

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e              state_q;
  logic [IN_W-1:0]     shift_q;
  logic [AccW-1:0]     acc_q;
  logic [CntW-1:0]     cnt_q;
  logic                neg_q;
  logic                busy_q;
  logic                ovf_q;
  logic [3:0]          disp_q [N_DIGITS];

  logic [IdxW-1:0]     idx_q;
  logic [3:0]          bcd_q;
  logic [N_DIGITS-1:0] sel_q;

  logic [IN_W-1:0]     mag;
  logic [AccW-1:0]     acc_adj;
  logic [AccW-1:0]     acc_shift;
  logic [PadW-1:0]     acc_pad;
  logic [3:0]          disp_new [N_DIGITS];
  logic                ovf_new;
  int                  msd;
  int                  need;

  // Magnitude of the input; -2^(IN_W-1) maps to 2^(IN_W-1), which still fits unsigned.
  always_comb begin
    mag = value;
    if (signed_mode && value[IN_W-1]) mag = -value;
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(NBcd); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[AccW-2:0], shift_q[IN_W-1]};
  end

  // Final display image: blank leading zeros, place the sign, or flag overflow.
  always_comb begin
    acc_pad = PadW'(acc_q);
    msd     = 0;
    for (int i = 0; i < int'(NBcd); i++) begin
      if (acc_pad[4*i +: 4] != 4'd0) msd = i;
    end
    need    = msd + 1 + (neg_q ? 1 : 0);
    ovf_new = (need > int'(N_DIGITS));
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (ovf_new)                     disp_new[i] = 4'he;
      else if (i <= msd)               disp_new[i] = acc_pad[4*i +: 4];
      else if (neg_q && i == msd + 1)  disp_new[i] = 4'ha;
      else                             disp_new[i] = 4'hf;
    end
  end

  // Conversion FSM: accept load in idle, shift IN_W bits, then commit atomically.
  always_ff @(posedge clk2) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) disp_q[i] <= (i == 0) ? 4'h0 : 4'hf;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            shift_q <= mag;
            neg_q   <= signed_mode & value[IN_W-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StConv;
          end
        end
        StConv: begin
          acc_q   <= acc_shift;
          shift_q <= shift_q << 1;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CntW'(IN_W - 1)) state_q <= StCommit;
        end
        StCommit: begin
          for (int i = 0; i < int'(N_DIGITS); i++) disp_q[i] <= disp_new[i];
          ovf_q   <= ovf_new;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Digit scanner: on each tick, latch the active digit and its anode, then advance.
  always_ff @(posedge clk2) begin
    if (rst) begin
      idx_q <= '0;
      sel_q <= '1;
      bcd_q <= 4'hf;
    end else if (scan_tick) begin
      sel_q <= ~({{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q);
      bcd_q <= disp_q[idx_q];
      idx_q <= (idx_q == IdxW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  assign BCD      = bcd_q;
  assign sel_an   = sel_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner: a 4-digit and a 2-digit instance, 8-bit input.
module tb_bcd_digit_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance
  logic       a_rst = 1'b1, a_sm = 1'b0, a_load = 1'b0, a_tick = 1'b0;
  logic [7:0] a_value = '0;
  logic [3:0] a_bcd, a_sel;
  logic       a_busy, a_ovf;

  // 2-digit instance
  logic       b_rst = 1'b1, b_sm = 1'b0, b_load = 1'b0, b_tick = 1'b0;
  logic [7:0] b_value = '0;
  logic [3:0] b_bcd;
  logic [1:0] b_sel;
  logic       b_busy, b_ovf;

  int n_pass = 0, n_total = 0, n_fail = 0;
  int a_idx = 0, b_idx = 0;

  bcd_digit_scanner #(.N_DIGITS(4), .IN_W(8)) u_a (
    .clk2(clk), .rst(a_rst), .value(a_value), .signed_mode(a_sm), .load(a_load),
    .scan_tick(a_tick), .BCD(a_bcd), .sel_an(a_sel), .busy(a_busy), .overflow(a_ovf)
  );

  bcd_digit_scanner #(.N_DIGITS(2), .IN_W(8)) u_b (
    .clk2(clk), .rst(b_rst), .value(b_value), .signed_mode(b_sm), .load(b_load),
    .scan_tick(b_tick), .BCD(b_bcd), .sel_an(b_sel), .busy(b_busy), .overflow(b_ovf)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock on instance A: inputs set at negedge, outputs sampled 1ns after posedge.
  task automatic cyc_a(input logic ld, input logic tk);
    @(negedge clk);
    a_load = ld;
    a_tick = tk;
    @(posedge clk);
    #1;
    a_load = 1'b0;
    a_tick = 1'b0;
  endtask

  task automatic cyc_b(input logic ld, input logic tk);
    @(negedge clk);
    b_load = ld;
    b_tick = tk;
    @(posedge clk);
    #1;
    b_load = 1'b0;
    b_tick = 1'b0;
  endtask

  // Four ticks; exp packs digits {d3,d2,d1,d0}.
  task automatic show_a(input string tag, input logic [15:0] exp);
    logic [3:0] e_sel;
    logic [3:0] e_dig;
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b0, 1'b1);
      e_sel = ~(4'b0001 << a_idx);
      e_dig = exp[4*a_idx +: 4];
      chk({tag, " sel"}, {12'h0, a_sel}, {12'h0, e_sel});
      chk({tag, " digit"}, {12'h0, a_bcd}, {12'h0, e_dig});
      a_idx = (a_idx + 1) % 4;
    end
  endtask

  task automatic show_b(input string tag, input logic [7:0] exp);
    logic [1:0] e_sel;
    logic [3:0] e_dig;
    for (int i = 0; i < 2; i++) begin
      cyc_b(1'b0, 1'b1);
      e_sel = ~(2'b01 << b_idx);
      e_dig = exp[4*b_idx +: 4];
      chk({tag, " sel"}, {14'h0, b_sel}, {14'h0, e_sel});
      chk({tag, " digit"}, {12'h0, b_bcd}, {12'h0, e_dig});
      b_idx = (b_idx + 1) % 2;
    end
  endtask

  task automatic wait_a(input string tag);
    for (int i = 0; i < 50 && a_busy; i++) cyc_a(1'b0, 1'b0);
    chk({tag, " idle"}, {15'h0, a_busy}, 16'h0);
  endtask

  task automatic wait_b(input string tag);
    for (int i = 0; i < 50 && b_busy; i++) cyc_b(1'b0, 1'b0);
    chk({tag, " idle"}, {15'h0, b_busy}, 16'h0);
  endtask

  initial begin
    // Reset with load and tick asserted: reset must win.
    a_value = 8'd77;
    cyc_a(1'b1, 1'b1);
    cyc_a(1'b1, 1'b1);
    chk("rst sel", {12'h0, a_sel}, 16'h000f);
    chk("rst bcd", {12'h0, a_bcd}, 16'h000f);
    chk("rst busy", {15'h0, a_busy}, 16'h0);
    chk("rst ovf", {15'h0, a_ovf}, 16'h0);
    a_rst = 1'b0;
    a_idx = 0;
    cyc_a(1'b0, 1'b1);
    chk("first tick sel", {12'h0, a_sel}, 16'h000e);
    chk("first tick bcd", {12'h0, a_bcd}, 16'h0000);
    a_idx = 1;
    show_a("reset disp", 16'hfff0);

    // Unsigned 207: busy for exactly 9 cycles.
    a_value = 8'd207;
    a_sm    = 1'b0;
    cyc_a(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      chk("busy 207", {15'h0, a_busy}, 16'h1);
      cyc_a(1'b0, 1'b0);
    end
    chk("busy 207 end", {15'h0, a_busy}, 16'h0);
    chk("ovf 207", {15'h0, a_ovf}, 16'h0);
    show_a("u207", 16'hf207);

    // Signed -13 and -128.
    a_value = 8'hf3;
    a_sm    = 1'b1;
    cyc_a(1'b1, 1'b0);
    wait_a("m13");
    show_a("m13", 16'hfa13);
    a_value = 8'h80;
    cyc_a(1'b1, 1'b0);
    wait_a("m128");
    chk("ovf m128", {15'h0, a_ovf}, 16'h0);
    show_a("m128", 16'ha128);

    // Second load during busy is dropped.
    a_sm    = 1'b0;
    a_value = 8'd5;
    cyc_a(1'b1, 1'b0);
    cyc_a(1'b0, 1'b0);
    a_value = 8'd99;
    cyc_a(1'b1, 1'b0);
    cyc_a(1'b1, 1'b0);
    wait_a("ign");
    show_a("ign", 16'hfff5);

    // Reset mid-conversion discards it.
    a_value = 8'd99;
    cyc_a(1'b1, 1'b0);
    cyc_a(1'b0, 1'b0);
    cyc_a(1'b0, 1'b0);
    a_rst = 1'b1;
    cyc_a(1'b0, 1'b0);
    a_rst = 1'b0;
    a_idx = 0;
    chk("midrst busy", {15'h0, a_busy}, 16'h0);
    chk("midrst sel", {12'h0, a_sel}, 16'h000f);
    for (int i = 0; i < 12; i++) cyc_a(1'b0, 1'b0);
    chk("midrst no commit", {15'h0, a_busy}, 16'h0);
    show_a("midrst", 16'hfff0);

    // Tick on the commit edge shows the old digit; new content from the next tick.
    a_value = 8'd42;
    cyc_a(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc_a(1'b0, 1'b0);
    chk("pre commit busy", {15'h0, a_busy}, 16'h1);
    cyc_a(1'b0, 1'b1);
    chk("coincide sel", {12'h0, a_sel}, 16'h000e);
    chk("coincide old digit", {12'h0, a_bcd}, 16'h0000);
    chk("coincide busy", {15'h0, a_busy}, 16'h0);
    a_idx = 1;
    show_a("u42", 16'hff42);

    // Two-digit instance: overflow then recovery.
    cyc_b(1'b0, 1'b0);
    b_rst = 1'b0;
    b_idx = 0;
    b_value = 8'd255;
    cyc_b(1'b1, 1'b0);
    wait_b("b255");
    chk("b255 ovf", {15'h0, b_ovf}, 16'h1);
    show_b("b255", 8'hee);
    b_value = 8'd9;
    cyc_b(1'b1, 1'b0);
    wait_b("b9");
    chk("b9 ovf", {15'h0, b_ovf}, 16'h0);
    show_b("b9", 8'hf9);
    b_sm    = 1'b1;
    b_value = 8'hf3;
    cyc_b(1'b1, 1'b0);
    wait_b("bm13");
    chk("bm13 ovf", {15'h0, b_ovf}, 16'h1);
    show_b("bm13", 8'hee);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_digit_scanner.md
BCD_DIGIT_SCANNER -- requirements
Module: bcd_digit_scanner

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter IN_W, default 8, input value width in bits (legal 4..16).
REQ-003 SHALL have port clk2  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port value  input  IN_W  binary value to display.
REQ-006 SHALL have port signed_mode  input  1  1 = value is two's complement, 0 = unsigned.
REQ-007 SHALL have port load  input  1  single-cycle request to convert value.
REQ-008 SHALL have port scan_tick  input  1  one-cycle enable advancing the active digit.
REQ-009 SHALL have port BCD  output  4  code of active digit: 0-9 digit, 4'ha minus, 4'he overflow, 4'hf blank.
REQ-010 SHALL have port sel_an  output  N_DIGITS  active-low anode select, one-cold.
REQ-011 SHALL have port busy  output  1  conversion in progress.
REQ-012 SHALL have port overflow  output  1  last committed value did not fit.

Function
REQ-013 SHALL hold N_DIGITS display registers; digit 0 is least significant, rightmost.
REQ-014 SHALL use states IDLE, CONV, COMMIT; IDLE->CONV on load, CONV->COMMIT after exactly IN_W cycles, COMMIT->IDLE after 1 cycle.
REQ-015 SHALL sample value and signed_mode only on the edge where load=1 in IDLE; load in CONV or COMMIT is ignored, not queued.
REQ-016 SHALL take magnitude = -value when signed_mode=1 and value MSB=1, else value; -2^(IN_W-1) yields magnitude 2^(IN_W-1), not truncated.
REQ-017 SHALL convert by shift-add-3 (double dabble), one bit per CONV cycle, MSB first.
REQ-018 SHALL assert busy for exactly IN_W+1 cycles (CONV plus COMMIT), starting the cycle after load is accepted.
REQ-019 SHALL, in COMMIT, write all display registers atomically; scanning shows old contents until then.
REQ-020 SHALL blank (4'hf) every digit above the most significant nonzero digit; digit 0 is always shown, so zero displays "0".
REQ-021 SHALL, for negative values, place 4'ha in the digit immediately left of the most significant shown digit.
REQ-022 SHALL set overflow=1 and write 4'he to all digits when required positions (digits plus sign) exceed N_DIGITS; otherwise overflow=0; overflow updates only in COMMIT.
REQ-023 SHALL keep a digit index 0..N_DIGITS-1 that increments on scan_tick and wraps N_DIGITS-1 -> 0.
REQ-024 SHALL register BCD and sel_an on scan_tick: sel_an = all ones except bit idx = 0, BCD = display[idx]; both hold between ticks.
REQ-025 SHALL scan independently of conversion state; scan_tick during CONV/COMMIT is honoured.
REQ-026 SHALL, when the COMMIT edge and scan_tick coincide, output the pre-commit digit on that tick and new content from the next tick.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, force: state IDLE, index 0, sel_an all ones, BCD 4'hf, busy 0, overflow 0, display[0]=0, other digits 4'hf.
REQ-028 SHALL give rst priority over load and scan_tick in the same cycle; rst mid-CONV discards the conversion with no commit.
REQ-029 SHALL make the first scan_tick after reset show sel_an=...1110, BCD=0.

Verification (N_DIGITS=4, IN_W=8 unless stated)
REQ-030 Reset, then 1 tick -> sel_an 1111/BCD f during reset; after tick sel_an 1110, BCD 0.
REQ-031 load 8'd207 unsigned -> busy high 9 cycles; ticks give digits 0..3 = 7,0,2,f; overflow 0.
REQ-032 signed load 8'hF3 (-13) -> 3,1,a,f; signed 8'h80 (-128) -> 8,2,1,a.
REQ-033 N_DIGITS=2: unsigned 8'd255 -> overflow 1, both digits e; then load 8'd9 -> 9,f, overflow 0.
REQ-034 load 8'd5, second load 8'd99 during busy -> only 5 committed; rst during CONV -> reset display, busy 0.
REQ-035 8 consecutive ticks -> sel_an 1110,1101,1011,0111 repeating; tick coinciding with COMMIT shows old digit.
